// File: rtl/qracc_bus_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qracc_bus_initiator                                                      |
// | Streams weights, activations and scalers into QRAcc, then reads the      |
// | output fmap back out on a sink stream.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qracc_bus_initiator #(
  parameter int NUM_ROWS       = 256,
  parameter int NUM_SCALERS    = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                n_input_bits,
  input  logic [31:0]               input_fmap_size,
  input  logic [31:0]               output_fmap_size,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [DATA_BUS_WIDTH-1:0] src_data,
  output logic                      ctrl_start_o,
  output logic                      bus_valid,
  output logic                      bus_wen,
  output logic [DATA_BUS_WIDTH-1:0] bus_data_out,
  input  logic                      bus_ready,
  input  logic                      bus_rd_data_valid,
  input  logic [DATA_BUS_WIDTH-1:0] bus_rd_data,
  output logic                      snk_valid,
  input  logic                      snk_ready,
  output logic [DATA_BUS_WIDTH-1:0] snk_data,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic [2:0]                phase_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICK    = 3'd1,
    S_WEIGHTS = 3'd2,
    S_ACTS    = 3'd3,
    S_SCALERS = 3'd4,
    S_READ    = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  localparam logic [31:0] W_WORDS = 32'(NUM_ROWS);
  localparam logic [31:0] S_WORDS = 32'(NUM_SCALERS);
  localparam logic [4:0]  LG_DW   = 5'($clog2(DATA_BUS_WIDTH));

  state_t                    state_q, state_d;
  logic [31:0]               beat_q, beat_d;
  logic [31:0]               load_q, load_d;
  logic [31:0]               a_tgt_q, a_tgt_d;
  logic [31:0]               r_tgt_q, r_tgt_d;
  logic                      bus_valid_q, bus_valid_d;
  logic                      bus_wen_q, bus_wen_d;
  logic [DATA_BUS_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                      pending_q, pending_d;
  logic                      snk_valid_q, snk_valid_d;
  logic [DATA_BUS_WIDTH-1:0] snk_data_q, snk_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      ctrl_start_q, ctrl_start_d;

  logic        cfg_ok;
  logic [4:0]  epw_sh;
  logic [31:0] epw_m1;
  logic [31:0] a_words;
  logic [31:0] phase_tgt;
  logic        in_wr;
  logic        bus_hs;
  logic        src_fire;
  logic        last_beat;
  logic        snk_hs;
  logic        rd_cap;
  logic        rd_issue;

  // Elements per word is a power of two, so the ceiling divide is a shift plus remainder test.
  always_comb begin
    cfg_ok = 1'b1;
    epw_sh = LG_DW;
    case (n_input_bits)
      4'd1:    epw_sh = LG_DW;
      4'd2:    epw_sh = LG_DW - 5'd1;
      4'd4:    epw_sh = LG_DW - 5'd2;
      4'd8:    epw_sh = LG_DW - 5'd3;
      default: cfg_ok = 1'b0;
    endcase
    epw_m1  = (32'd1 << epw_sh) - 32'd1;
    a_words = (input_fmap_size >> epw_sh) + {31'd0, |(input_fmap_size & epw_m1)};
  end

  always_comb begin
    phase_tgt = 32'd0;
    case (state_q)
      S_WEIGHTS: phase_tgt = W_WORDS;
      S_ACTS:    phase_tgt = a_tgt_q;
      S_SCALERS: phase_tgt = S_WORDS;
      default:   phase_tgt = 32'd0;
    endcase
  end

  assign in_wr     = (state_q == S_WEIGHTS) || (state_q == S_ACTS) || (state_q == S_SCALERS);
  assign bus_hs    = bus_valid_q && bus_ready;
  assign src_ready = in_wr && (load_q != phase_tgt) && (!bus_valid_q || bus_hs);
  assign src_fire  = src_valid && src_ready;
  assign last_beat = in_wr && bus_hs && (beat_q == phase_tgt - 32'd1);
  assign snk_hs    = snk_valid_q && snk_ready;
  assign rd_cap    = bus_rd_data_valid && pending_q;
  assign rd_issue  = (state_q == S_READ) && !bus_valid_q && !pending_q &&
                     (load_q != r_tgt_q) && (!snk_valid_q || snk_hs);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    load_d       = load_q;
    a_tgt_d      = a_tgt_q;
    r_tgt_d      = r_tgt_q;
    bus_valid_d  = bus_valid_q;
    bus_data_d   = bus_data_q;
    pending_d    = pending_q;
    snk_valid_d  = snk_valid_q;
    snk_data_d   = snk_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cfg_err_d    = cfg_err_q;
    ctrl_start_d = 1'b0;

    if (snk_hs) snk_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d      = S_KICK;
            busy_d       = 1'b1;
            cfg_err_d    = 1'b0;
            ctrl_start_d = 1'b1;
            a_tgt_d      = a_words;
            r_tgt_d      = output_fmap_size;
            beat_d       = 32'd0;
            load_d       = 32'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_KICK: state_d = S_WEIGHTS;
      S_WEIGHTS, S_ACTS, S_SCALERS: begin
        if (src_fire) begin
          bus_valid_d = 1'b1;
          bus_data_d  = src_data;
          load_d      = load_q + 32'd1;
        end else if (bus_hs) begin
          bus_valid_d = 1'b0;
        end
        if (bus_hs) beat_d = beat_q + 32'd1;
        if (last_beat) begin
          beat_d = 32'd0;
          load_d = 32'd0;
          if (state_q == S_WEIGHTS) state_d = (a_tgt_q == 32'd0) ? S_SCALERS : S_ACTS;
          else if (state_q == S_ACTS) state_d = S_SCALERS;
          else state_d = S_READ;
        end
      end
      S_READ: begin
        if (r_tgt_q == 32'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (bus_hs) begin
            bus_valid_d = 1'b0;
            pending_d   = 1'b1;
          end else if (rd_issue) begin
            bus_valid_d = 1'b1;
            load_d      = load_q + 32'd1;
          end
          // A request is only issued with the sink free, so a capture never overwrites.
          if (rd_cap) begin
            pending_d   = 1'b0;
            snk_valid_d = 1'b1;
            snk_data_d  = bus_rd_data;
            beat_d      = beat_q + 32'd1;
            if (beat_q == r_tgt_q - 32'd1) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (snk_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          beat_d  = 32'd0;
          load_d  = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bus_wen_d = (state_d == S_WEIGHTS) || (state_d == S_ACTS) || (state_d == S_SCALERS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      load_q       <= '0;
      a_tgt_q      <= '0;
      r_tgt_q      <= '0;
      bus_valid_q  <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_data_q   <= '0;
      pending_q    <= 1'b0;
      snk_valid_q  <= 1'b0;
      snk_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      ctrl_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      load_q       <= load_d;
      a_tgt_q      <= a_tgt_d;
      r_tgt_q      <= r_tgt_d;
      bus_valid_q  <= bus_valid_d;
      bus_wen_q    <= bus_wen_d;
      bus_data_q   <= bus_data_d;
      pending_q    <= pending_d;
      snk_valid_q  <= snk_valid_d;
      snk_data_q   <= snk_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      ctrl_start_q <= ctrl_start_d;
    end
  end

  assign ctrl_start_o = ctrl_start_q;
  assign bus_valid    = bus_valid_q;
  assign bus_wen      = bus_wen_q;
  assign bus_data_out = bus_data_q;
  assign snk_valid    = snk_valid_q;
  assign snk_data     = snk_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign phase_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_qracc_bus_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qracc_bus_initiator                                                   |
// | Scoreboard bench: source/responder drivers push expectations, monitor    |
// | pops them on every bus write beat and sink handshake.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_qracc_bus_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  n_input_bits = 4'd0;
  logic [31:0] input_fmap_size = 32'd0;
  logic [31:0] output_fmap_size = 32'd0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [31:0] src_data = 32'd0;
  logic        ctrl_start_o;
  logic        bus_valid;
  logic        bus_wen;
  logic [31:0] bus_data_out;
  logic        bus_ready = 1'b0;
  logic        bus_rd_data_valid = 1'b0;
  logic [31:0] bus_rd_data = 32'd0;
  logic        snk_valid;
  logic        snk_ready = 1'b0;
  logic [31:0] snk_data;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [2:0]  phase_o;

  qracc_bus_initiator dut (
    .clk(clk), .rst(rst), .start(start), .n_input_bits(n_input_bits),
    .input_fmap_size(input_fmap_size), .output_fmap_size(output_fmap_size),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .ctrl_start_o(ctrl_start_o), .bus_valid(bus_valid), .bus_wen(bus_wen),
    .bus_data_out(bus_data_out), .bus_ready(bus_ready),
    .bus_rd_data_valid(bus_rd_data_valid), .bus_rd_data(bus_rd_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .phase_o(phase_o)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_wr[$];
  int          exp_ph[$];
  logic [31:0] exp_rd[$];

  int   req_cnt = 0, rsp_cnt = 0, done_cnt = 0, kick_cnt = 0, wr_cnt = 0;
  bit   rsp_active = 0;
  bit   src_stall = 0, bus_stall = 0, snk_stall = 0, snk_hold = 0, junk_en = 0;
  int   rd_lat = 0, rd_wait = 0, rd_idx = 0;
  logic [7:0] cur_tag = 8'h00;

  bit          bv_p = 0, sv_p = 0, s_src_hs = 0;
  logic [31:0] bd_p = 0, sd_p = 0, e_word = 0;
  int          e_ph = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] tag, input int ph, input int idx);
    logic [31:0] w;
    w = {tag, ph[7:0], idx[15:0]};
    src_q.push_back(w);
    exp_wr.push_back(w);
    exp_ph.push_back(ph);
  endtask

  task automatic push_layer(input logic [7:0] tag, input int a);
    for (int i = 0; i < 256; i++) push_word(tag, 2, i);
    for (int i = 0; i < a; i++)   push_word(tag, 3, i);
    for (int i = 0; i < 32; i++)  push_word(tag, 4, i);
  endtask

  task automatic set_flags(input bit ss, input bit bs, input bit ks, input bit jk, input int lat);
    @(negedge clk); #1;
    src_stall = ss; bus_stall = bs; snk_stall = ks; junk_en = jk; rd_lat = lat; snk_hold = 0;
  endtask

  task automatic pulse_start(input logic [3:0] nb, input logic [31:0] isz, input logic [31:0] r);
    @(posedge clk); #1;
    n_input_bits = nb; input_fmap_size = isz; output_fmap_size = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the config inputs so a design that fails to latch them goes wrong.
    n_input_bits = 4'd3; input_fmap_size = 32'h0000_FFFF; output_fmap_size = 32'd999;
  endtask

  // a_exp is the hand-computed activation word count for the vector.
  task automatic run_layer(input logic [3:0] nb, input logic [31:0] isz, input int r, input int a_exp,
                           input logic [7:0] tag, input bit hold);
    int d0, k0, rq0, w0, t, rqh;
    cur_tag = tag;
    push_layer(tag, a_exp);
    d0 = done_cnt; k0 = kick_cnt; rq0 = req_cnt; w0 = wr_cnt;
    pulse_start(nb, isz, r);
    chk("busy_after_start", busy, 1);
    chk("phase_kick", phase_o, 1);
    chk("ctrl_start_pulse", ctrl_start_o, 1);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; n_input_bits = 4'd2;
    @(posedge clk); #1 start = 1'b0;
    if (hold) begin
      for (t = 0; t < 4000; t++) begin
        @(negedge clk);
        if (phase_o == 3'd5 && snk_valid) break;
      end
      chk("hold_reached_read", phase_o, 5);
      #1 snk_hold = 1;
      repeat (3) @(posedge clk);
      rqh = req_cnt;
      repeat (17) @(posedge clk);
      #1;
      chk("no_read_during_hold", req_cnt - rqh, 0);
      chk("snk_valid_during_hold", snk_valid, 1);
      @(negedge clk); #1 snk_hold = 0;
    end
    for (t = 0; t < 6000 && done_cnt == d0; t++) @(posedge clk);
    if (done_cnt == d0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: actual=no done required=done within 6000 cycles");
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("kick_once", kick_cnt - k0, 1);
    chk("write_count", wr_cnt - w0, 288 + a_exp);
    chk("read_count", req_cnt - rq0, r);
    chk("wr_queue_left", exp_wr.size(), 0);
    chk("rd_queue_left", exp_rd.size(), 0);
    chk("busy_end", busy, 0);
    chk("phase_end", phase_o, 0);
  endtask

  // Source, bus responder and sink drivers
  initial begin
    forever begin
      @(negedge clk);
      s_src_hs = src_valid && src_ready;
      @(posedge clk); #1;
      if (rst) begin
        src_valid = 0; bus_ready = 0; snk_ready = 0; bus_rd_data_valid = 0;
        rsp_active = 0; rsp_cnt = req_cnt; rd_wait = 0;
      end else begin
        if (s_src_hs && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && !(src_stall && $urandom_range(0, 2) == 0)) begin
          src_valid = 1; src_data = src_q[0];
        end else begin
          src_valid = 0;
        end
        bus_ready = bus_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        snk_ready = snk_hold ? 1'b0 : (snk_stall ? 1'($urandom_range(0, 1)) : 1'b1);
        if (bus_rd_data_valid) begin
          bus_rd_data_valid = 0; rsp_active = 0;
        end else if (req_cnt > rsp_cnt) begin
          if (rd_wait <= 0) begin
            bus_rd_data_valid = 1;
            bus_rd_data = {cur_tag, 8'hD0, rd_idx[15:0]};
            exp_rd.push_back(bus_rd_data);
            rd_idx++; rsp_cnt++; rsp_active = 1;
            rd_wait = $urandom_range(0, rd_lat);
          end else begin
            rd_wait--;
          end
        end else if (junk_en && $urandom_range(0, 3) == 0) begin
          bus_rd_data_valid = 1; bus_rd_data = 32'hBAD0_0000;
        end
      end
    end
  end

  // Monitor: stability, ordering and outstanding-read checks
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bv_p = 0; sv_p = 0;
      end else begin
        if (bv_p) begin
          chk("bus_valid_held", bus_valid, 1);
          chk("bus_data_held", bus_data_out, bd_p);
        end
        if (sv_p) begin
          chk("snk_valid_held", snk_valid, 1);
          chk("snk_data_held", snk_data, sd_p);
        end
        if (bus_valid && bus_ready) begin
          if (bus_wen) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL extra_write: actual=%0h required=no write", bus_data_out);
            end else begin
              e_word = exp_wr.pop_front();
              e_ph = exp_ph.pop_front();
              chk("wr_data", bus_data_out, e_word);
              chk("wr_phase", phase_o, e_ph);
            end
          end else begin
            chk("one_read_outstanding", {31'd0, (req_cnt == rsp_cnt) && !rsp_active}, 1);
            chk("read_phase", phase_o, 5);
            req_cnt++;
          end
        end
        if (snk_valid && snk_ready) begin
          if (exp_rd.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL extra_sink_word: actual=%0h required=no word", snk_data);
          end else begin
            e_word = exp_rd.pop_front();
            chk("snk_data", snk_data, e_word);
          end
        end
        if (done) done_cnt++;
        if (ctrl_start_o) kick_cnt++;
        bv_p = bus_valid && !bus_ready; bd_p = bus_data_out;
        sv_p = snk_valid && !snk_ready; sd_p = snk_data;
      end
    end
  end

  initial begin
    #800000;
    n_err++;
    $display("FAIL watchdog: actual=still running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0, t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {src_ready, ctrl_start_o, bus_valid, bus_wen, snk_valid, busy, done, cfg_err}, 0);
    chk("rst_bus_data", bus_data_out, 0);
    chk("rst_snk_data", snk_data, 0);
    chk("rst_phase", phase_o, 0);
    @(negedge clk); rst = 0;

    // Nominal layer: 256 + 8 + 32 writes, 16 reads
    set_flags(0, 0, 0, 0, 0);
    run_layer(4'd4, 32'd64, 16, 8, 8'h01, 0);
    // Ceiling and empty-ifmap cases
    set_flags(0, 0, 0, 0, 0);
    run_layer(4'd4, 32'd65, 4, 9, 8'h02, 0);
    set_flags(0, 0, 0, 0, 0);
    run_layer(4'd8, 32'd0, 2, 0, 8'h03, 0);
    // Random stalls on every interface
    set_flags(1, 1, 1, 0, 3);
    run_layer(4'd2, 32'd40, 8, 3, 8'h04, 0);
    // Sink held off in READ, stray rd_data_valid pulses
    set_flags(0, 0, 0, 1, 0);
    run_layer(4'd1, 32'd33, 6, 2, 8'h05, 1);

    // Illegal precision
    set_flags(0, 0, 0, 0, 0);
    k0 = kick_cnt;
    pulse_start(4'd3, 32'd16, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_phase", phase_o, 0);
    chk("cfg_err_no_kick", kick_cnt - k0, 0);
    repeat (5) @(posedge clk);
    #1 chk("cfg_err_sticky", cfg_err, 1);
    run_layer(4'd8, 32'd9, 0, 3, 8'h06, 0);
    chk("cfg_err_cleared", cfg_err, 0);

    // Reset in the middle of ACTS
    set_flags(0, 0, 0, 0, 0);
    cur_tag = 8'h07;
    push_layer(8'h07, 8);
    pulse_start(4'd4, 32'd64, 32'd4);
    for (t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (phase_o == 3'd3) break;
    end
    chk("reached_acts", phase_o, 3);
    #2 rst = 1;
    #1;
    chk("midrst_outputs", {src_ready, ctrl_start_o, bus_valid, bus_wen, snk_valid, busy, done, cfg_err}, 0);
    chk("midrst_bus_data", bus_data_out, 0);
    chk("midrst_phase", phase_o, 0);
    src_q.delete(); exp_wr.delete(); exp_ph.delete(); exp_rd.delete();
    repeat (3) @(posedge clk);
    #1 chk("midrst_held_busy", busy, 0);
    @(negedge clk); #3 rst = 0;
    set_flags(0, 0, 0, 0, 0);
    run_layer(4'd8, 32'd8, 3, 2, 8'h08, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
